// File: rtl/ro_ctrl_pkg.sv
// rtl/ro_ctrl_pkg.sv - shared types and defaults for the ring-oscillator measurement sequencer
package ro_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        GATE,
        STOP
    } state_t;

    localparam int RO_SEL_W          = 4;
    localparam int RO_STAGE_W        = 5;
    localparam int DEF_CNT_W         = 24;
    localparam int DEF_GATE_W        = 20;
    localparam int DEF_SETTLE_CYCLES = 64;
    localparam int DEF_NUM_RO        = 16;

endpackage

// File: rtl/ro_edge_counter.sv
// rtl/ro_edge_counter.sv - synchronised rising-edge counter with saturation and sticky overflow
module ro_edge_counter #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ro_in,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    logic sync1_q, sync2_q, prev_q;
    logic rise;

    // prev_q trails sync2_q so an edge is seen exactly once after two flops of metastability filtering
    assign rise = sync2_q & ~prev_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            sync1_q <= ro_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (clear) begin
                count    <= '0;
                overflow <= 1'b0;
            end else if (enable && rise) begin
                if (&count) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ro_measure_ctrl.sv
// rtl/ro_measure_ctrl.sv - ring-oscillator select/start sequencer and gated frequency counter
// Optional build macro RO_SWEEP_EN: measure every oscillator 0..NUM_RO-1 per request.
module ro_measure_ctrl
    import ro_ctrl_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int GATE_W        = DEF_GATE_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int NUM_RO        = DEF_NUM_RO
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  meas_req_i,
    input  logic                  abort_i,
    input  logic [RO_SEL_W-1:0]   cfg_sel_i,
    input  logic [RO_STAGE_W-1:0] cfg_stage_i,
    input  logic [GATE_W-1:0]     cfg_gate_i,
    input  logic                  ro_in_i,
    output logic                  ro_start_o,
    output logic [RO_STAGE_W-1:0] ro_s_o,
    output logic [RO_SEL_W-1:0]   ro_sel_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_W-1:0]      result_o,
    output logic [RO_SEL_W-1:0]   result_idx_o,
    output logic                  overflow_o
);

`ifdef RO_SWEEP_EN
    localparam bit SWEEP = 1'b1;
`else
    localparam bit SWEEP = 1'b0;
`endif

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES) + 1;
    localparam int TMR_W    = (GATE_W > SETTLE_W) ? GATE_W : SETTLE_W;
    localparam logic [RO_SEL_W-1:0] LAST_SEL = RO_SEL_W'(NUM_RO - 1);

    state_t                  state_q, state_d;
    logic [TMR_W-1:0]        timer_q;
    logic [RO_SEL_W-1:0]     sel_q;
    logic [RO_STAGE_W-1:0]   stage_q;
    logic [GATE_W-1:0]       gate_q;
    logic                    sweep_last;
    logic [CNT_W-1:0]        count;
    logic                    cnt_overflow;

    // Single-shot builds always finish after one STOP; sweeps finish on the last index.
    assign sweep_last = !SWEEP || (sel_q == LAST_SEL);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (meas_req_i) state_d = SETTLE;
            SETTLE: if (abort_i) state_d = IDLE;
                    else if (timer_q == '0) state_d = GATE;
            GATE:   if (abort_i) state_d = IDLE;
                    else if (timer_q == '0) state_d = STOP;
            STOP:   if (abort_i || sweep_last) state_d = IDLE;
                    else state_d = SETTLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            sel_q        <= '0;
            stage_q      <= '0;
            gate_q       <= '0;
            done_o       <= 1'b0;
            result_o     <= '0;
            result_idx_o <= '0;
            overflow_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_o  <= (state_q == STOP);
            case (state_q)
                IDLE: if (meas_req_i) begin
                    sel_q   <= SWEEP ? '0 : cfg_sel_i;
                    stage_q <= cfg_stage_i;
                    gate_q  <= (cfg_gate_i == '0) ? GATE_W'(1) : cfg_gate_i;
                    timer_q <= TMR_W'(SETTLE_CYCLES - 1);
                end
                SETTLE: timer_q <= (timer_q == '0) ? TMR_W'(gate_q) - 1'b1 : timer_q - 1'b1;
                GATE:   timer_q <= timer_q - 1'b1;
                STOP: begin
                    result_o     <= count;
                    result_idx_o <= sel_q;
                    overflow_o   <= cnt_overflow;
                    if (!abort_i && !sweep_last) begin
                        sel_q   <= sel_q + 1'b1;
                        timer_q <= TMR_W'(SETTLE_CYCLES - 1);
                    end
                end
                default: timer_q <= '0;
            endcase
        end
    end

    assign ro_start_o = (state_q == SETTLE) || (state_q == GATE);
    assign busy_o     = (state_q != IDLE);
    assign ro_s_o     = stage_q;
    assign ro_sel_o   = sel_q;

    ro_edge_counter #(
        .CNT_W(CNT_W)
    ) u_edge_counter (
        .clk      (wb_clk_i),
        .resetn   (wb_rst_ni),
        .ro_in    (ro_in_i),
        .clear    (state_q == SETTLE),
        .enable   (state_q == GATE),
        .count    (count),
        .overflow (cnt_overflow)
    );

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// tb/tb_ro_measure_ctrl.sv - self-checking bench for ro_measure_ctrl (4-bit counter build)
module tb_ro_measure_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        meas_req;
    logic        abort;
    logic [3:0]  cfg_sel;
    logic [4:0]  cfg_stage;
    logic [19:0] cfg_gate;
    logic        ro_in;
    logic        ro_start;
    logic [4:0]  ro_s;
    logic [3:0]  ro_sel;
    logic        busy;
    logic        done;
    logic [3:0]  result;
    logic [3:0]  result_idx;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ro_half = 0;

    typedef struct {
        logic [3:0] sel;
        logic [4:0] stage;
        int         gate;
        int         half;
        int         exp_min;
        int         exp_max;
        logic       exp_ovf;
        int         exp_lat;
        bit         mid_req;
        bit         with_abort;
    } vec_t;

    typedef struct {
        logic [3:0] sel;
        int         exp_min;
        int         exp_max;
        logic       exp_ovf;
        int         exp_lat;
        int         t0;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];

    ro_measure_ctrl #(
        .CNT_W(4), .GATE_W(20), .SETTLE_CYCLES(64), .NUM_RO(16)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (resetn),
        .meas_req_i   (meas_req),
        .abort_i      (abort),
        .cfg_sel_i    (cfg_sel),
        .cfg_stage_i  (cfg_stage),
        .cfg_gate_i   (cfg_gate),
        .ro_in_i      (ro_in),
        .ro_start_o   (ro_start),
        .ro_s_o       (ro_s),
        .ro_sel_o     (ro_sel),
        .busy_o       (busy),
        .done_o       (done),
        .result_o     (result),
        .result_idx_o (result_idx),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Free-running oscillator model, deliberately skewed off the clock edge.
    initial begin
        int hc;
        hc = 0;
        ro_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ro_half == 0) begin
                ro_in = 1'b0;
                hc = 0;
            end else begin
                hc++;
                if (hc >= ro_half) begin
                    hc = 0;
                    ro_in = ~ro_in;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ro_start"}, ro_start, 0);
        chk({tag, "_ro_s"}, ro_s, 0);
        chk({tag, "_ro_sel"}, ro_sel, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_result_idx"}, result_idx, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int n;
        @(negedge clk);
        ro_half   = v.half;
        cfg_sel   = v.sel;
        cfg_stage = v.stage;
        cfg_gate  = 20'(v.gate);
        meas_req  = 1'b1;
        abort     = v.with_abort;
        e.sel = v.sel; e.exp_min = v.exp_min; e.exp_max = v.exp_max;
        e.exp_ovf = v.exp_ovf; e.exp_lat = v.exp_lat; e.t0 = cyc;
        sb.push_back(e);
        @(negedge clk);
        meas_req = 1'b0;
        abort    = 1'b0;
        cfg_sel  = ~v.sel;
        chk("settle_ro_start", ro_start, 1);
        chk("settle_ro_sel", ro_sel, v.sel);
        chk("settle_ro_s", ro_s, v.stage);
        chk("settle_busy", busy, 1);
        n = 1;
        while (!done && n < 2000) begin
            meas_req = (v.mid_req && n == 10);
            @(negedge clk);
            n++;
        end
        meas_req = 1'b0;
        e = sb.pop_front();
        if (!done) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk_rng("result", result, e.exp_min, e.exp_max);
            chk("result_idx", result_idx, e.sel);
            chk("overflow", overflow, e.exp_ovf);
            chk("latency", cyc - e.t0, e.exp_lat);
            chk("done_ro_start", ro_start, 0);
            chk("done_busy", busy, 0);
        end
        @(negedge clk);
        chk("done_pulse_width", done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        int t0;
        int dcount;
        vecs[0] = '{4'd3,  5'b00001, 100, 4,  12, 13, 1'b0, 166, 1'b0, 1'b0};
        vecs[1] = '{4'd5,  5'b10101, 100, 2,  15, 15, 1'b1, 166, 1'b0, 1'b0};
        vecs[2] = '{4'd15, 5'b11111, 0,   4,  0,  1,  1'b0, 67,  1'b0, 1'b0};
        vecs[3] = '{4'd0,  5'b00010, 80,  4,  10, 10, 1'b0, 146, 1'b1, 1'b0};
        vecs[4] = '{4'd9,  5'b01000, 60,  10, 3,  3,  1'b0, 126, 1'b0, 1'b1};
        vecs[5] = '{4'd12, 5'b00100, 120, 4,  15, 15, 1'b0, 186, 1'b0, 1'b0};
        vecs[6] = '{4'd6,  5'b10000, 50,  0,  0,  0,  1'b0, 116, 1'b0, 1'b0};
        vecs[7] = '{4'd7,  5'b11000, 128, 4,  15, 15, 1'b1, 194, 1'b0, 1'b0};

        resetn = 1'b0; meas_req = 1'b0; abort = 1'b0;
        cfg_sel = '0; cfg_stage = '0; cfg_gate = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        resetn = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Abort in the middle of the gate window: previous result (vector 7) must survive.
        @(negedge clk);
        cfg_sel = 4'd2; cfg_stage = 5'b00011; cfg_gate = 20'd100; ro_half = 4;
        meas_req = 1'b1; t0 = cyc;
        @(negedge clk);
        meas_req = 1'b0;
        while (cyc - t0 < 115) @(negedge clk);
        chk("pre_abort_ro_start", ro_start, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ro_start", ro_start, 0);
        chk("abort_ro_sel_hold", ro_sel, 2);
        dcount = 0;
        repeat (150) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", dcount, 0);
        chk("abort_result_kept", result, 15);
        chk("abort_idx_kept", result_idx, 7);
        chk("abort_ovf_kept", overflow, 1);

        // Synchronous reset pulled in the middle of GATE.
        cfg_sel = 4'd11; cfg_stage = 5'b00111; cfg_gate = 20'd100;
        meas_req = 1'b1; t0 = cyc;
        @(negedge clk);
        meas_req = 1'b0;
        while (cyc - t0 < 100) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        resetn = 1'b0;
        @(negedge clk);
        chk_all_zero("midreset");
        resetn = 1'b1;

        run_vec(vecs[0]);

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required=0", cyc);
        $fatal(1, "timeout");
    end

endmodule
